user_event_gen: RTL and testbench

Producer side of the user-event stream consumed by the game logic. Decodes a byte stream of PS/2 set-2 keyboard scancodes into `user_event_t` events and buffers them in a small show-ahead FIFO exposed as `user_event_o` / `user_event_ready_o` / `user_event_rd_req_i`. Sits between the PS/2 byte receiver and the game FSM, in the same clock domain as the game FSM.

---
 rtl/user_event_gen.sv | 149 ++++++++++++++
 tb/tb_user_event_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_event_gen.sv
// PS/2 set-2 scancode decoder feeding a small show-ahead FIFO
// of user events for the game FSM.
package user_event_pkg;
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_DOWN     = 3'd3,
    EV_ROTATE   = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;
endpackage

module user_event_gen
  import user_event_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int PREFIX_TIMEOUT = 2_500_000
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic [7:0]  scancode_i,
  input  logic        scancode_valid_i,
  output user_event_t user_event_o,
  output logic        user_event_ready_o,
  input  logic        user_event_rd_req_i,
  output logic [7:0]  overflow_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE_S,
    EXT_S,
    BREAK_S,
    EXT_BREAK_S
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  user_event_t     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  user_event_t     ev;
  logic            push;
  logic            full;
  logic            do_pop;
  logic            do_push;

  always_comb begin
    ev = EV_NONE;
    if (scancode_valid_i) begin
      unique case (state)
        IDLE_S: begin
          unique case (1'b1)
            (scancode_i == 8'h1C): ev = EV_LEFT;
            (scancode_i == 8'h23): ev = EV_RIGHT;
            (scancode_i == 8'h1B): ev = EV_DOWN;
            (scancode_i == 8'h1D): ev = EV_ROTATE;
            (scancode_i == 8'h5A): ev = EV_NEW_GAME;
            default:               ev = EV_NONE;
          endcase
        end
        EXT_S: begin
          unique case (1'b1)
            (scancode_i == 8'h6B): ev = EV_LEFT;
            (scancode_i == 8'h74): ev = EV_RIGHT;
            (scancode_i == 8'h72): ev = EV_DOWN;
            (scancode_i == 8'h75): ev = EV_ROTATE;
            default:               ev = EV_NONE;
          endcase
        end
        default: ev = EV_NONE;
      endcase
    end
    push = (ev != EV_NONE);
  end

  // A received byte always wins over an expiring prefix timeout.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state   <= IDLE_S;
      tmo_cnt <= '0;
    end else if (scancode_valid_i) begin
      tmo_cnt <= '0;
      unique case (state)
        IDLE_S: begin
          if (scancode_i == 8'hE0)
            state <= EXT_S;
          else if (scancode_i == 8'hF0)
            state <= BREAK_S;
          else
            state <= IDLE_S;
        end
        EXT_S: begin
          if (scancode_i == 8'hF0)
            state <= EXT_BREAK_S;
          else if (scancode_i == 8'hE0)
            state <= EXT_S;
          else
            state <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end else if (state != IDLE_S) begin
      if (tmo_cnt == TW'(PREFIX_TIMEOUT - 1)) begin
        state   <= IDLE_S;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = user_event_rd_req_i && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push && srst_n_i)
      mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      overflow_cnt_o <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
      if (push && !do_push && overflow_cnt_o != 8'hFF)
        overflow_cnt_o <= overflow_cnt_o + 1'b1;
    end
  end

  assign user_event_ready_o = (count != '0);
  assign user_event_o = user_event_ready_o ? mem[rd_ptr] : EV_NONE;

endmodule

// File: tb/tb_user_event_gen.sv
// Directed and random bench for user_event_gen against a
// queue-based reference model of the decoder and FIFO.
module tb_user_event_gen;
  import user_event_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int M_NONE = 0;
  localparam int M_EXT  = 1;
  localparam int M_REL  = 2;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic [7:0]  scancode = 8'h00;
  logic        scancode_valid = 1'b0;
  logic        rd_req = 1'b0;
  user_event_t user_event;
  logic        ready;
  logic [7:0]  ovf_cnt;

  int total = 0;
  int bad = 0;

  user_event_t q[$];
  int m_mode = M_NONE;
  int m_idle = 0;
  int m_ovf = 0;

  always #5 clk = ~clk;

  user_event_gen #(
    .DEPTH(DEPTH),
    .PREFIX_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk),
    .srst_n_i(srst_n),
    .scancode_i(scancode),
    .scancode_valid_i(scancode_valid),
    .user_event_o(user_event),
    .user_event_ready_o(ready),
    .user_event_rd_req_i(rd_req),
    .overflow_cnt_o(ovf_cnt)
  );

  function automatic user_event_t key_ev(logic [7:0] b, bit ext);
    if (ext) begin
      case (b)
        8'h6B: return EV_LEFT;
        8'h74: return EV_RIGHT;
        8'h72: return EV_DOWN;
        8'h75: return EV_ROTATE;
        default: return EV_NONE;
      endcase
    end
    case (b)
      8'h1C: return EV_LEFT;
      8'h23: return EV_RIGHT;
      8'h1B: return EV_DOWN;
      8'h1D: return EV_ROTATE;
      8'h5A: return EV_NEW_GAME;
      default: return EV_NONE;
    endcase
  endfunction

  task automatic model_edge(bit rst, bit v, logic [7:0] b, bit pop);
    user_event_t e;
    bit full;
    bit pop_ok;
    e = EV_NONE;
    if (rst) begin
      q.delete();
      m_mode = M_NONE;
      m_idle = 0;
      m_ovf = 0;
      return;
    end
    if (v) begin
      m_idle = 0;
      if (m_mode == M_REL) begin
        m_mode = M_NONE;
      end else if (b == 8'hE0) begin
        m_mode = M_EXT;
      end else if (b == 8'hF0) begin
        m_mode = M_REL;
      end else begin
        e = key_ev(b, m_mode == M_EXT);
        m_mode = M_NONE;
      end
    end else if (m_mode != M_NONE) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_mode = M_NONE;
        m_idle = 0;
      end
    end
    full = (q.size() == DEPTH);
    pop_ok = pop && (q.size() != 0);
    if (pop_ok)
      void'(q.pop_front());
    if (e != EV_NONE) begin
      if (!full || pop_ok)
        q.push_back(e);
      else if (m_ovf < 255)
        m_ovf++;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit rst, bit v, logic [7:0] b, bit pop,
                      string tag);
    srst_n = !rst;
    scancode_valid = v;
    scancode = b;
    rd_req = pop;
    @(posedge clk);
    model_edge(rst, v, b, pop);
    #1;
    chk({tag, ".rdy"}, {7'd0, ready}, {7'd0, q.size() != 0});
    chk({tag, ".ovf"}, ovf_cnt, 8'(m_ovf));
    if (q.size() != 0)
      chk({tag, ".head"}, 8'(user_event), 8'(q[0]));
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++)
      step(0, 0, 8'h00, 0, tag);
  endtask

  task automatic send(logic [7:0] b, string tag);
    step(0, 1, b, 0, tag);
  endtask

  task automatic pop1(string tag);
    step(0, 0, 8'h00, 1, tag);
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1B, 8'h1D,
                            8'h5A, 8'h6B, 8'h74, 8'h72, 8'h75, 8'h11};

  initial begin
    user_event_t exp4 [4];

    // reset held with a valid make code on the bus
    step(1, 1, 8'h1C, 0, "rst0");
    chk("rst0.ev", 8'(user_event), 8'h00);
    step(1, 1, 8'h1C, 0, "rst1");
    chk("rst1.ev", 8'(user_event), 8'h00);
    chk("rst1.ovfc", ovf_cnt, 8'h00);

    // extended make, extended release, enter
    send(8'hE0, "t2.e0");
    chk("t2.nordy", {7'd0, ready}, 8'h00);
    send(8'h75, "t2.75");
    chk("t2.lat", {7'd0, ready}, 8'h01);
    send(8'hE0, "t2.e0b");
    send(8'hF0, "t2.f0");
    send(8'h75, "t2.75b");
    send(8'h5A, "t2.5a");
    idle(1, "t2.idle");
    chk("t2.h0", 8'(user_event), 8'(EV_ROTATE));
    pop1("t2.p0");
    chk("t2.h1", 8'(user_event), 8'(EV_NEW_GAME));
    pop1("t2.p1");
    chk("t2.empty", {7'd0, ready}, 8'h00);

    // overflow on the fifth push
    send(8'h1C, "t3.a");
    send(8'h23, "t3.b");
    send(8'h1B, "t3.c");
    send(8'h1D, "t3.d");
    send(8'h1C, "t3.e");
    chk("t3.ovf1", ovf_cnt, 8'h01);
    exp4 = '{EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE};
    for (int i = 0; i < 4; i++) begin
      chk("t3.order", 8'(user_event), 8'(exp4[i]));
      pop1("t3.pop");
    end
    chk("t3.empty", {7'd0, ready}, 8'h00);

    // simultaneous push and pop while full
    send(8'h1C, "t4.a");
    send(8'h23, "t4.b");
    send(8'h1B, "t4.c");
    send(8'h1D, "t4.d");
    step(0, 1, 8'h23, 1, "t4.pp");
    chk("t4.noovf", ovf_cnt, 8'h01);
    exp4 = '{EV_RIGHT, EV_DOWN, EV_ROTATE, EV_RIGHT};
    for (int i = 0; i < 4; i++) begin
      chk("t4.order", 8'(user_event), 8'(exp4[i]));
      pop1("t4.pop");
    end
    chk("t4.empty", {7'd0, ready}, 8'h00);

    // prefix timeout, and a gap shorter than the timeout
    send(8'hE0, "t5.e0");
    idle(TMO + 2, "t5.wait");
    send(8'h6B, "t5.6b");
    chk("t5.noev", {7'd0, ready}, 8'h00);
    send(8'h1C, "t5.1c");
    chk("t5.left", 8'(user_event), 8'(EV_LEFT));
    pop1("t5.p0");
    send(8'hE0, "t5.e0b");
    idle(TMO / 2, "t5.short");
    send(8'h6B, "t5.6bb");
    chk("t5.extleft", 8'(user_event), 8'(EV_LEFT));
    pop1("t5.p1");

    // release of A then enter; pops on empty fifo
    send(8'hF0, "t6.f0");
    send(8'h1C, "t6.1c");
    send(8'h5A, "t6.5a");
    chk("t6.head", 8'(user_event), 8'(EV_NEW_GAME));
    pop1("t6.p0");
    chk("t6.one", {7'd0, ready}, 8'h00);
    pop1("t6.pe0");
    pop1("t6.pe1");
    chk("t6.norr", {7'd0, ready}, 8'h00);
    send(8'h1D, "t6.1d");
    chk("t6.rot", 8'(user_event), 8'(EV_ROTATE));
    pop1("t6.p1");

    // reset mid-sequence discards the prefix
    send(8'hE0, "t7.e0");
    step(1, 0, 8'h00, 0, "t7.rst");
    send(8'h6B, "t7.6b");
    chk("t7.noev", {7'd0, ready}, 8'h00);

    // overflow counter saturation
    for (int i = 0; i < DEPTH + 300; i++)
      send(8'h1C, "t8.fill");
    chk("t8.sat", ovf_cnt, 8'hFF);
    step(1, 0, 8'h00, 0, "t8.rst");

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        step(1, 0, 8'h00, 0, "rnd.rst");
      end else if ($urandom_range(0, 99) == 0) begin
        idle($urandom_range(TMO - 2, TMO + 2), "rnd.gap");
      end else begin
        step(0, $urandom_range(0, 9) < 6,
             pool[$urandom_range(0, 11)],
             $urandom_range(0, 9) < 4, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
